// File: rtl/axis_adc_acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_adc_acq_pkg
//  Description : Shared state, trigger-source and edge encodings for the
//                ADC acquisition controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_adc_acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } acq_state_t;

    localparam logic [1:0] C_TRIG_SRC_CHA   = 2'b00;
    localparam logic [1:0] C_TRIG_SRC_CHB   = 2'b01;
    localparam logic [1:0] C_TRIG_SRC_EXT   = 2'b10;
    localparam logic [1:0] C_TRIG_SRC_FORCE = 2'b11;

    localparam logic C_EDGE_RISING  = 1'b0;
    localparam logic C_EDGE_FALLING = 1'b1;

    localparam int C_SAMPLE_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/axis_adc_acq_ctrl_trig.sv
`default_nettype none
// ============================================================================
//  Module      : adc_trig_detect
//  Description : Edge history, signed level comparison and ext/force trigger
//                logic; emits a single-cycle trigger pulse while armed.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_trig_detect
    import axis_adc_acq_pkg::*;
(
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      i_enable,
    input  logic                      i_clear,
    input  logic [1:0]                i_trig_src,
    input  logic                      i_trig_edge,
    input  logic [C_SAMPLE_WIDTH-1:0] i_trig_level,
    input  logic [31:0]               i_s_axis_tdata,
    input  logic                      i_s_axis_tvalid,
    input  logic                      i_ext_trig,
    output logic                      o_trig_pulse
);

    logic signed [C_SAMPLE_WIDTH-1:0] r_prev_sample;
    logic                             r_hist_valid;
    logic                             r_prev_ext;

    logic signed [C_SAMPLE_WIDTH-1:0] w_cur_sample;
    logic signed [C_SAMPLE_WIDTH-1:0] w_level;
    logic                             w_level_rise;
    logic                             w_level_fall;
    logic                             w_chan_hit;
    logic                             w_ext_hit;
    logic                             w_hit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_prev_sample <= '0;
            r_hist_valid  <= 1'b0;
            r_prev_ext    <= 1'b0;
        end else begin
            r_prev_ext <= i_ext_trig;
            if (i_clear) begin
                r_prev_sample <= '0;
                r_hist_valid  <= 1'b0;
            end else if (i_enable && i_s_axis_tvalid) begin
                r_prev_sample <= w_cur_sample;
                r_hist_valid  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_cur_sample = (i_trig_src == C_TRIG_SRC_CHB) ? $signed(i_s_axis_tdata[31:16])
                                                      : $signed(i_s_axis_tdata[15:0]);
        w_level      = $signed(i_trig_level);
        w_level_rise = (r_prev_sample < w_level) && (w_cur_sample >= w_level);
        w_level_fall = (r_prev_sample > w_level) && (w_cur_sample <= w_level);
        // No history yet means no previous sample, so channel triggers are blocked.
        w_chan_hit   = r_hist_valid &&
                       ((i_trig_edge == C_EDGE_FALLING) ? w_level_fall : w_level_rise);
        w_ext_hit    = (i_trig_edge == C_EDGE_FALLING) ? (r_prev_ext && !i_ext_trig)
                                                       : (!r_prev_ext && i_ext_trig);
        case (i_trig_src)
            C_TRIG_SRC_CHA,
            C_TRIG_SRC_CHB:   w_hit = w_chan_hit;
            C_TRIG_SRC_EXT:   w_hit = w_ext_hit;
            C_TRIG_SRC_FORCE: w_hit = 1'b1;
            default:          w_hit = 1'b0;
        endcase
        o_trig_pulse = i_enable && i_s_axis_tvalid && w_hit;
    end

endmodule
`default_nettype wire

// File: rtl/axis_adc_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axis_adc_acq_ctrl
//  Description : Triggered ADC capture onto AXI-Stream with a single output
//                register stage, overrun detection and trigger timestamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_adc_acq_ctrl
    import axis_adc_acq_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int TS_WIDTH  = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [31:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    input  logic                      cfg_arm,
    input  logic                      cfg_abort,
    input  logic [1:0]                cfg_trig_src,
    input  logic                      cfg_trig_edge,
    input  logic [C_SAMPLE_WIDTH-1:0] cfg_trig_level,
    input  logic [CNT_WIDTH-1:0]      cfg_length,
    input  logic                      ext_trig,
    output logic [1:0]                sts_state,
    output logic                      sts_overrun,
    output logic [TS_WIDTH-1:0]       sts_trig_ts
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TS_WIDTH-1:0]  C_TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};

    acq_state_t                r_state;
    acq_state_t                w_state_next;

    logic [1:0]                r_cfg_src;
    logic                      r_cfg_edge;
    logic [C_SAMPLE_WIDTH-1:0] r_cfg_level;
    logic [CNT_WIDTH-1:0]      r_cfg_length;

    logic [CNT_WIDTH-1:0]      r_count;
    logic [31:0]               r_m_tdata;
    logic                      r_m_tvalid;
    logic                      r_m_tlast;
    logic                      r_overrun;
    logic [TS_WIDTH-1:0]       r_ts;
    logic [TS_WIDTH-1:0]       r_trig_ts;

    logic                      w_trig_pulse;
    logic                      w_trig;
    logic                      w_arm_ok;
    logic                      w_out_free;
    logic                      w_capture_open;
    logic                      w_accept;
    logic                      w_drop;
    logic [CNT_WIDTH-1:0]      w_count_next;
    logic                      w_last;

    adc_trig_detect u_trig (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .i_enable        (r_state == ST_ARMED),
        .i_clear         (w_arm_ok),
        .i_trig_src      (r_cfg_src),
        .i_trig_edge     (r_cfg_edge),
        .i_trig_level    (r_cfg_level),
        .i_s_axis_tdata  (s_axis_tdata),
        .i_s_axis_tvalid (s_axis_tvalid),
        .i_ext_trig      (ext_trig),
        .o_trig_pulse    (w_trig_pulse)
    );

    always_comb begin
        w_trig         = w_trig_pulse && !cfg_abort;
        w_arm_ok       = cfg_arm && !cfg_abort &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_out_free     = !r_m_tvalid || m_axis_tready;
        // Once the terminal count is reached, later samples are ignored, not dropped.
        w_capture_open = (r_state == ST_CAPTURE) && (r_count != r_cfg_length);
        w_accept       = !cfg_abort &&
                         (w_trig || (w_capture_open && s_axis_tvalid && w_out_free));
        w_drop         = !cfg_abort && w_capture_open && s_axis_tvalid && !w_out_free;
        w_count_next   = w_trig ? C_CNT_ONE : (r_count + C_CNT_ONE);
        w_last         = (w_count_next == r_cfg_length);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (cfg_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE,
                ST_DONE:    if (cfg_arm) w_state_next = ST_ARMED;
                ST_ARMED:   if (w_trig) w_state_next = ST_CAPTURE;
                ST_CAPTURE: if (r_m_tvalid && m_axis_tready && r_m_tlast)
                                w_state_next = ST_DONE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cfg_src    <= '0;
            r_cfg_edge   <= 1'b0;
            r_cfg_level  <= '0;
            r_cfg_length <= '0;
            r_count      <= '0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_overrun    <= 1'b0;
            r_ts         <= '0;
            r_trig_ts    <= '0;
        end else begin
            r_ts <= r_ts + C_TS_ONE;

            if (w_arm_ok) begin
                r_cfg_src    <= cfg_trig_src;
                r_cfg_edge   <= cfg_trig_edge;
                r_cfg_level  <= cfg_trig_level;
                r_cfg_length <= (cfg_length == '0) ? C_CNT_ONE : cfg_length;
                r_count      <= '0;
                r_overrun    <= 1'b0;
            end

            if (w_trig) begin
                r_trig_ts <= r_ts;
            end
            if (w_accept) begin
                r_count <= w_count_next;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (cfg_abort) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end else if (w_accept) begin
                r_m_tdata  <= s_axis_tdata;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_last;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign sts_state     = r_state;
    assign sts_overrun   = r_overrun;
    assign sts_trig_ts   = r_trig_ts;

endmodule
`default_nettype wire

// File: tb/tb_axis_adc_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_adc_acq_ctrl
//  Description : Scoreboard bench for axis_adc_acq_ctrl with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_adc_acq_ctrl;

    localparam int CNT_WIDTH = 16;
    localparam int TS_WIDTH  = 32;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic [31:0]          s_axis_tdata = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic [31:0]          m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b0;
    logic                 m_axis_tlast;
    logic                 cfg_arm = 1'b0;
    logic                 cfg_abort = 1'b0;
    logic [1:0]           cfg_trig_src = '0;
    logic                 cfg_trig_edge = 1'b0;
    logic [15:0]          cfg_trig_level = '0;
    logic [CNT_WIDTH-1:0] cfg_length = '0;
    logic                 ext_trig = 1'b0;
    logic [1:0]           sts_state;
    logic                 sts_overrun;
    logic [TS_WIDTH-1:0]  sts_trig_ts;

    int                   n_checks = 0;
    int                   n_pass = 0;
    logic [32:0]          exp_q[$];
    logic [TS_WIDTH-1:0]  tb_ts;
    logic [TS_WIDTH-1:0]  ts_mark;

    always #5 aclk = ~aclk;

    axis_adc_acq_ctrl #(
        .CNT_WIDTH (CNT_WIDTH),
        .TS_WIDTH  (TS_WIDTH)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .cfg_arm        (cfg_arm),
        .cfg_abort      (cfg_abort),
        .cfg_trig_src   (cfg_trig_src),
        .cfg_trig_edge  (cfg_trig_edge),
        .cfg_trig_level (cfg_trig_level),
        .cfg_length     (cfg_length),
        .ext_trig       (ext_trig),
        .sts_state      (sts_state),
        .sts_overrun    (sts_overrun),
        .sts_trig_ts    (sts_trig_ts)
    );

    // Reference free-running cycle counter, restarted by reset.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) tb_ts <= '0;
        else          tb_ts <= tb_ts + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: actual tdata=%h tlast=%b, required no beat",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("beat", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e});
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample(input logic [15:0] a, input logic [15:0] b);
        s_axis_tdata  = {b, a};
        s_axis_tvalid = 1'b1;
        cyc();
    endtask

    task automatic arm(input logic [1:0] src, input logic edg, input logic [15:0] lvl,
                       input logic [CNT_WIDTH-1:0] len);
        cfg_trig_src   = src;
        cfg_trig_edge  = edg;
        cfg_trig_level = lvl;
        cfg_length     = len;
        s_axis_tvalid  = 1'b0;
        cfg_arm        = 1'b1;
        cyc();
        cfg_arm        = 1'b0;
        // Scramble inputs so only the latched copy can steer the capture.
        cfg_trig_src   = 2'b00;
        cfg_trig_edge  = 1'b0;
        cfg_trig_level = 16'h0000;
        cfg_length     = 16'd3;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_state",   {62'd0, sts_state}, 64'd0);
        check("rst_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tdata",   {32'd0, m_axis_tdata}, 64'd0);
        check("rst_overrun", {63'd0, sts_overrun}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();
        m_axis_tready = 1'b1;

        // Rising trigger on channel A at level 100, length 4.
        arm(2'b00, 1'b0, 16'd100, 16'd4);
        check("t1_armed", {62'd0, sts_state}, 64'd1);
        exp_q.push_back({1'b0, 16'h0000, 16'd100});
        exp_q.push_back({1'b0, 16'h0000, 16'd105});
        exp_q.push_back({1'b0, 16'h0000, 16'd110});
        exp_q.push_back({1'b1, 16'h0000, 16'd115});
        sample(16'd90, 16'd0);
        sample(16'd95, 16'd0);
        ts_mark = tb_ts;
        sample(16'd100, 16'd0);
        check("t1_capture", {62'd0, sts_state}, 64'd2);
        for (int k = 0; k < 5; k++) sample(16'd105 + 16'(5 * k), 16'd0);
        s_axis_tvalid = 1'b0;
        cyc();
        check("t1_done",    {62'd0, sts_state}, 64'd3);
        check("t1_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("t1_trig_ts", {32'd0, sts_trig_ts}, {32'd0, ts_mark});
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // Falling trigger on channel B at -50; first sample of -50 must not fire.
        arm(2'b01, 1'b1, 16'hFFCE, 16'd2);
        exp_q.push_back({1'b0, 16'hFFCE, 16'h0007});
        exp_q.push_back({1'b1, 16'hFFC4, 16'h0007});
        sample(16'h0007, 16'hFFCE);
        check("t2_no_first_trig", {62'd0, sts_state}, 64'd1);
        sample(16'h0007, 16'h0000);
        sample(16'h0007, 16'hFFCE);
        sample(16'h0007, 16'hFFC4);
        sample(16'h0007, 16'h0000);
        s_axis_tvalid = 1'b0;
        cyc();
        check("t2_done",    {62'd0, sts_state}, 64'd3);
        check("t2_overrun", {63'd0, sts_overrun}, 64'd0);

        // Force trigger, length 8, ready low for trigger cycle and two more.
        arm(2'b11, 1'b0, 16'd0, 16'd8);
        exp_q.push_back({1'b0, 32'h0000_0100});
        for (int k = 3; k <= 8; k++) exp_q.push_back({1'b0, 16'h0000, 16'h0100 + 16'(k)});
        exp_q.push_back({1'b1, 32'h0000_0109});
        for (int k = 0; k < 12; k++) begin
            m_axis_tready = (k >= 3);
            sample(16'h0100 + 16'(k), 16'h0000);
        end
        s_axis_tvalid = 1'b0;
        cyc();
        check("t3_overrun", {63'd0, sts_overrun}, 64'd1);
        check("t3_done",    {62'd0, sts_state}, 64'd3);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Abort together with arm on the third capture cycle.
        arm(2'b11, 1'b0, 16'd0, 16'd10);
        check("t4_overrun_cleared", {63'd0, sts_overrun}, 64'd0);
        exp_q.push_back({1'b0, 32'h0000_0200});
        exp_q.push_back({1'b0, 32'h0000_0201});
        exp_q.push_back({1'b0, 32'h0000_0202});
        sample(16'h0200, 16'h0000);
        sample(16'h0201, 16'h0000);
        sample(16'h0202, 16'h0000);
        cfg_abort = 1'b1;
        cfg_arm   = 1'b1;
        sample(16'h0203, 16'h0000);
        cfg_abort = 1'b0;
        cfg_arm   = 1'b0;
        check("t4_idle",   {62'd0, sts_state}, 64'd0);
        check("t4_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        sample(16'h0204, 16'h0000);
        sample(16'h0205, 16'h0000);
        s_axis_tvalid = 1'b0;
        cyc();
        check("t4_stay_idle", {62'd0, sts_state}, 64'd0);

        // External rising trigger, only on a 0->1 transition with a valid sample.
        arm(2'b10, 1'b0, 16'd0, 16'd1);
        exp_q.push_back({1'b1, 32'h0000_0304});
        ext_trig = 1'b0;
        sample(16'h0300, 16'h0000);
        sample(16'h0301, 16'h0000);
        ext_trig = 1'b1;
        s_axis_tvalid = 1'b0;
        cyc();
        sample(16'h0302, 16'h0000);
        ext_trig = 1'b0;
        sample(16'h0303, 16'h0000);
        check("t5_still_armed", {62'd0, sts_state}, 64'd1);
        ext_trig = 1'b1;
        sample(16'h0304, 16'h0000);
        ext_trig = 1'b0;
        sample(16'h0305, 16'h0000);
        s_axis_tvalid = 1'b0;
        cyc();
        check("t5_done", {62'd0, sts_state}, 64'd3);

        // Force trigger with length 0 behaves as length 1.
        arm(2'b11, 1'b0, 16'd0, 16'd0);
        exp_q.push_back({1'b1, 32'h0000_0400});
        ts_mark = tb_ts;
        sample(16'h0400, 16'h0000);
        sample(16'h0401, 16'h0000);
        sample(16'h0402, 16'h0000);
        s_axis_tvalid = 1'b0;
        cyc();
        check("t6_done",    {62'd0, sts_state}, 64'd3);
        check("t6_trig_ts", {32'd0, sts_trig_ts}, {32'd0, ts_mark});
        check("t6_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a stalled capture.
        arm(2'b11, 1'b0, 16'd0, 16'd20);
        m_axis_tready = 1'b0;
        sample(16'h0500, 16'h0000);
        sample(16'h0501, 16'h0000);
        check("t7_capture", {62'd0, sts_state}, 64'd2);
        check("t7_overrun", {63'd0, sts_overrun}, 64'd1);
        s_axis_tdata = 32'h0000_0502;
        #2;
        aresetn = 1'b0;
        #1;
        check("t7_rst_state",   {62'd0, sts_state}, 64'd0);
        check("t7_rst_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("t7_rst_tlast",   {63'd0, m_axis_tlast}, 64'd0);
        check("t7_rst_tdata",   {32'd0, m_axis_tdata}, 64'd0);
        check("t7_rst_overrun", {63'd0, sts_overrun}, 64'd0);
        check("t7_rst_trig_ts", {32'd0, sts_trig_ts}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cyc();
        cyc();
        check("t7_post_rst_idle", {62'd0, sts_state}, 64'd0);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_adc_acq_ctrl.md
AXIS_ADC_ACQ_CTRL -- requirements
Module: axis_adc_acq_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the capture-length counter.
REQ-002 SHALL have parameter TS_WIDTH, default 32, width of the free-running timestamp.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are listed in REQ-004 to REQ-020.
REQ-004 aclk  in  1  sole clock.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 s_axis_tdata  in  32  ADC samples: [15:0] channel A, [31:16] channel B, both signed two's complement.
REQ-007 s_axis_tvalid  in  1  sample strobe; no tready exists because the ADC cannot stall.
REQ-008 m_axis_tdata  out  32  captured sample.
REQ-009 m_axis_tvalid  out  1  output valid.
REQ-010 m_axis_tready  in  1  downstream ready.
REQ-011 m_axis_tlast  out  1  final sample of the capture.
REQ-012 cfg_arm  in  1  single-cycle arm request.
REQ-013 cfg_abort  in  1  single-cycle abort request.
REQ-014 cfg_trig_src  in  2  trigger source: 00 = channel A, 01 = channel B, 10 = ext_trig, 11 = force.
REQ-015 cfg_trig_edge  in  1  trigger edge: 0 = rising, 1 = falling.
REQ-016 cfg_trig_level  in  16  signed trigger threshold.
REQ-017 cfg_length  in  CNT_WIDTH  number of samples to capture.
REQ-018 ext_trig  in  1  external trigger, already synchronous to aclk.
REQ-019 sts_state  out  2  current state: 0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE.
REQ-020 sts_overrun  out  1  sticky overrun flag; sts_trig_ts  out  TS_WIDTH  timestamp latched at the trigger.

Function
REQ-021 SHALL implement the states IDLE, ARMED, CAPTURE and DONE.
REQ-022 cfg_arm in IDLE or DONE SHALL move to ARMED on the next cycle, latch all cfg_* inputs, clear sts_overrun and clear the edge history; cfg_arm in ARMED or CAPTURE SHALL be ignored.
REQ-023 cfg_abort SHALL move any state to IDLE on the next cycle and drop m_axis_tvalid; if cfg_abort and cfg_arm are asserted together, cfg_abort SHALL win.
REQ-024 Channel trigger SHALL be evaluated on valid samples only, using the previous and current sample of the selected channel, compared as signed values.
REQ-025 Rising edge condition: prev < level and cur >= level. Falling edge condition: prev > level and cur <= level.
REQ-026 A channel trigger SHALL require at least one valid sample seen since arming, so the first sample after arming can never trigger.
REQ-027 ext_trig SHALL fire on its 0->1 transition when rising is selected and on its 1->0 transition when falling is selected, on a cycle with s_axis_tvalid high.
REQ-028 Force (src 11) SHALL fire on the first valid sample in ARMED.
REQ-029 The triggering sample SHALL be the first captured sample; the state SHALL be CAPTURE from the next cycle.
REQ-030 sts_trig_ts SHALL latch the free-running timestamp on the trigger cycle; the timestamp counter SHALL wrap modulo 2^TS_WIDTH.
REQ-031 The output SHALL use a single register stage: a sample accepted in cycle n SHALL appear on m_axis in cycle n+1.
REQ-032 The output register SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable until m_axis_tready is high.
REQ-033 If a valid sample arrives while the output register is full and m_axis_tready is low, the sample SHALL be dropped, SHALL NOT be counted, and sts_overrun SHALL set.
REQ-034 cfg_length = 0 SHALL be treated as 1.
REQ-035 m_axis_tlast SHALL be high exactly on the cfg_length-th accepted sample.
REQ-036 After the last sample leaves the output register (tvalid and tready both high), the state SHALL move to DONE.
REQ-037 In CAPTURE, the counter reaching its terminal count and a new sample arriving in the same cycle SHALL NOT produce an extra sample.
REQ-038 In DONE, m_axis_tvalid SHALL be 0 and the block SHALL stay in DONE until cfg_arm or cfg_abort.

Reset
REQ-039 While aresetn is low: state IDLE; m_axis_tvalid, m_axis_tlast and m_axis_tdata 0; sts_overrun 0; sts_trig_ts 0; timestamp 0; counter 0; edge history cleared.
REQ-040 Assertion SHALL act asynchronously; deassertion SHALL be honoured on the first aclk edge after aresetn goes high.
REQ-041 Reset asserted mid-capture SHALL discard all captured samples and the latched configuration.

Structure
REQ-042 Package axis_adc_acq_pkg SHALL hold the state enumeration, the trig_src encodings and the edge encoding.
REQ-043 Sub-module adc_trig_detect SHALL hold the edge history, the level comparison and the ext/force trigger logic, and SHALL output a one-cycle trigger pulse.
REQ-044 The FSM, counter, output register and timestamp SHALL be in the top level.

Verification
REQ-045 Arm, rising, channel A, level 100, length 4, ramp A = 90, 95, 100, 105, ... -> capture starts at 100, then 105, 110, 115; tlast on 115; state goes to DONE.
REQ-046 Falling, channel B, level -50, B = 0, -50 -> trigger on -50; the first sample after arming, if it equals -50, does not trigger.
REQ-047 Length 8, m_axis_tready held low for 3 cycles during capture -> 2 samples dropped, sts_overrun = 1, exactly 8 samples delivered with tlast on the 8th.
REQ-048 cfg_abort on the 3rd capture cycle, asserted together with cfg_arm -> state IDLE next cycle, tvalid 0, no tlast emitted.
REQ-049 Force trigger, length 0 -> exactly one sample delivered with tlast = 1, sts_trig_ts equal to the timestamp on that cycle.
REQ-050 aresetn pulsed low mid-capture with no aclk edge -> all outputs take their reset values immediately.
